// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: sequencer for the shift_reg sample window.
//
// Turns sample strobes into one-cycle load_in_sync pulses. After each load it sweeps
// fifo_r_address through taps 0..NumTaps-1 so a downstream MAC/FIR stage can read the
// whole window, one tap per cycle. It also tracks window fill, holds one pending sample
// and flags overrun.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   synchronous reset, active HIGH (name kept for codebase consistency)
//   sample_valid   in   new sample on shift_reg data_in this cycle
//   flush          in   synchronous window invalidate
//   load_in_sync   out  shift strobe to shift_reg (sample data must be valid this cycle)
//   fifo_r_address out  tap select to shift_reg; 0 outside a sweep
//   tap_valid      out  fifo_r_data is a valid tap this cycle
//   tap_first      out  tap 0 (newest sample) of a sweep
//   tap_last       out  last tap of a sweep
//   busy           out  sequencer not idle
//   window_full    out  window holds NumTaps samples since reset/flush
//   overrun        out  sticky: a sample was dropped; cleared by flush or reset
module shift_reg_ctrl #(
    parameter int unsigned ADDR_WIDTH       = 2,
    parameter bit          READ_BEFORE_FULL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_valid,
    input  logic                  flush,
    output logic                  load_in_sync,
    output logic [ADDR_WIDTH-1:0] fifo_r_address,
    output logic                  tap_valid,
    output logic                  tap_first,
    output logic                  tap_last,
    output logic                  busy,
    output logic                  window_full,
    output logic                  overrun
);

    localparam int unsigned NumTaps = 2 ** ADDR_WIDTH;
    localparam int unsigned FillW   = $clog2(NumTaps + 1);

    localparam logic [FillW-1:0]      FullCnt  = FillW'(NumTaps);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {StIdle, StLoad, StRead} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [FillW-1:0]      fill_q, fill_d, fill_inc;
    logic                  pend_q, pend_d;
    logic                  ovr_q, ovr_d;

    logic go_load, take_pend, take_sv, keep_pend, extra_sv;

    always_comb begin
        state_d  = state_q;
        addr_d   = '0;
        fill_d   = fill_q;
        fill_inc = (fill_q == FullCnt) ? fill_q : fill_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (sample_valid) state_d = StLoad;
            end
            StLoad: begin
                fill_d = fill_inc;
                if (READ_BEFORE_FULL || (fill_inc == FullCnt)) begin
                    state_d = StRead;
                end else if (pend_q || sample_valid) begin
                    state_d = StLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StRead: begin
                if (addr_q == LastAddr) begin
                    state_d = (pend_q || sample_valid) ? StLoad : StIdle;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Entering LOAD consumes the pending sample first; a strobe arriving in the same
        // cycle then takes its place in the pending slot.
        go_load   = (state_d == StLoad);
        take_pend = go_load && pend_q;
        take_sv   = go_load && !pend_q && sample_valid;
        keep_pend = pend_q && !take_pend;
        extra_sv  = sample_valid && !take_sv;
        pend_d    = keep_pend || extra_sv;
        ovr_d     = ovr_q || (keep_pend && extra_sv);

        if (flush) begin
            state_d = StIdle;
            addr_d  = '0;
            fill_d  = '0;
            pend_d  = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // Outputs are registered from next-state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            fill_q       <= '0;
            pend_q       <= 1'b0;
            ovr_q        <= 1'b0;
            load_in_sync <= 1'b0;
            tap_valid    <= 1'b0;
            tap_first    <= 1'b0;
            tap_last     <= 1'b0;
            busy         <= 1'b0;
            window_full  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            fill_q       <= fill_d;
            pend_q       <= pend_d;
            ovr_q        <= ovr_d;
            load_in_sync <= (state_d == StLoad);
            tap_valid    <= (state_d == StRead);
            tap_first    <= (state_d == StRead) && (addr_d == '0);
            tap_last     <= (state_d == StRead) && (addr_d == LastAddr);
            busy         <= (state_d != StIdle);
            window_full  <= (fill_d == FullCnt);
        end
    end

    assign fifo_r_address = addr_q;
    assign overrun        = ovr_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
module tb_shift_reg_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic sample_valid = 1'b0;
    logic flush = 1'b0;

    logic       ld0, tv0, tf0, tl0, bz0, wf0, ov0;
    logic [1:0] ad0;
    logic       ld1, tv1, tf1, tl1, bz1, wf1, ov1;
    logic [1:0] ad1;

    shift_reg_ctrl #(.ADDR_WIDTH(2), .READ_BEFORE_FULL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .flush(flush),
        .load_in_sync(ld0), .fifo_r_address(ad0), .tap_valid(tv0), .tap_first(tf0),
        .tap_last(tl0), .busy(bz0), .window_full(wf0), .overrun(ov0)
    );

    shift_reg_ctrl #(.ADDR_WIDTH(2), .READ_BEFORE_FULL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .flush(flush),
        .load_in_sync(ld1), .fifo_r_address(ad1), .tap_valid(tv1), .tap_first(tf1),
        .tap_last(tl1), .busy(bz1), .window_full(wf1), .overrun(ov1)
    );

    // Behavioural shift_reg behind dut0: index 0 is the newest sample.
    int win[4];
    int next_smp = 1;
    always @(posedge clk) begin
        if (ld0 === 1'b1) begin
            win[3]   <= win[2];
            win[2]   <= win[1];
            win[1]   <= win[0];
            win[0]   <= next_smp;
            next_smp <= next_smp + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [8:0] obs0, obs1;  // {load, tap_valid, addr[1:0], first, last, busy, full, overrun}

    // Reference model: a schedule of upcoming cycles per DUT (0 = load, k = tap k-1).
    int sch[2][8];
    int slen[2];
    bit pend_m[2];
    bit ovr_m[2];
    int fill_m[2];
    int plan_m[2];

    task automatic model_clear(input int d);
        slen[d] = 0; pend_m[d] = 1'b0; ovr_m[d] = 1'b0; fill_m[d] = 0; plan_m[d] = 0;
    endtask

    function automatic logic [8:0] model_exp(input int d);
        int cur;
        logic [1:0] a;
        cur = (slen[d] > 0) ? sch[d][0] : -1;
        a = (cur >= 1) ? 2'(cur - 1) : 2'd0;
        return {cur == 0, cur >= 1, a, cur == 1, cur == 4, cur != -1, fill_m[d] >= 4, ovr_m[d]};
    endfunction

    task automatic model_adv(input int d, input bit s, input bit f, input bit r, input bit rbf);
        bit leftover;
        if (r || f) begin
            model_clear(d);
        end else begin
            if (slen[d] > 0) begin
                if (sch[d][0] == 0 && fill_m[d] < 4) fill_m[d]++;
                for (int i = 0; i < 7; i++) sch[d][i] = sch[d][i+1];
                slen[d]--;
            end
            leftover = s;
            if (slen[d] == 0 && (pend_m[d] || s)) begin
                if (pend_m[d]) pend_m[d] = 1'b0;
                else leftover = 1'b0;
                if (plan_m[d] < 4) plan_m[d]++;
                sch[d][0] = 0;
                slen[d] = 1;
                if (rbf || plan_m[d] == 4) begin
                    for (int k = 1; k <= 4; k++) sch[d][k] = k;
                    slen[d] = 5;
                end
            end
            if (leftover) begin
                if (pend_m[d]) ovr_m[d] = 1'b1;
                else pend_m[d] = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model.
    task automatic step(input bit s, input bit f = 1'b0, input bit r = 1'b0,
                        input bit tchk = 1'b0, input logic [8:0] texp = 9'd0);
        sample_valid = s;
        flush        = f;
        rst_n        = r;
        @(negedge clk);
        obs0 = {ld0, tv0, ad0, tf0, tl0, bz0, wf0, ov0};
        obs1 = {ld1, tv1, ad1, tf1, tl1, bz1, wf1, ov1};
        check("model dut0", 32'(obs0), 32'(model_exp(0)));
        check("model dut1", 32'(obs1), 32'(model_exp(1)));
        if (tchk) check("table dut0", 32'(obs0), 32'(texp));
        model_adv(0, s, f, r, 1'b0);
        model_adv(1, s, f, r, 1'b1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        bit         sv;
        bit         fl;
        logic [8:0] exp;
    } vec_t;

    vec_t tab[15];

    initial begin
        int base, nld, ntap, thr;
        logic [11:0] v_ld, v_tv, v_tf, v_tl, v_bz, v_ov;

        //             sv    fl    ld tv addr f l b w o
        tab[0]  = '{1'b1, 1'b0, 9'b0_0_00_0_0_0_0_0};
        tab[1]  = '{1'b1, 1'b0, 9'b1_0_00_0_0_1_0_0};
        tab[2]  = '{1'b1, 1'b0, 9'b1_0_00_0_0_1_0_0};
        tab[3]  = '{1'b1, 1'b0, 9'b1_0_00_0_0_1_0_0};
        tab[4]  = '{1'b0, 1'b0, 9'b1_0_00_0_0_1_0_0};
        tab[5]  = '{1'b1, 1'b0, 9'b0_1_00_1_0_1_1_0};
        tab[6]  = '{1'b1, 1'b0, 9'b0_1_01_0_0_1_1_0};
        tab[7]  = '{1'b0, 1'b0, 9'b0_1_10_0_0_1_1_1};
        tab[8]  = '{1'b0, 1'b0, 9'b0_1_11_0_1_1_1_1};
        tab[9]  = '{1'b0, 1'b0, 9'b1_0_00_0_0_1_1_1};
        tab[10] = '{1'b0, 1'b0, 9'b0_1_00_1_0_1_1_1};
        tab[11] = '{1'b0, 1'b1, 9'b0_1_01_0_0_1_1_1};
        tab[12] = '{1'b1, 1'b0, 9'b0_0_00_0_0_0_0_0};
        tab[13] = '{1'b0, 1'b0, 9'b1_0_00_0_0_1_0_0};
        tab[14] = '{1'b0, 1'b0, 9'b0_0_00_0_0_0_0_0};

        // Reset
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_clear(0);
        model_clear(1);

        // Table-driven: fast fill, pend, overrun, flush mid-sweep
        for (int i = 0; i < 15; i++) step(tab[i].sv, tab[i].fl, 1'b0, 1'b1, tab[i].exp);

        // Four strobes ten cycles apart from reset
        step(1'b0, 1'b0, 1'b1);
        base = next_smp;
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            nld = 0;
            ntap = 0;
            for (int j = 0; j < 9; j++) begin
                step(1'b0);
                if (j == 0) check("load one cycle after strobe", 32'(obs0[8]), 32'd1);
                if (obs0[8]) nld++;
                if (obs0[7]) begin
                    ntap++;
                    check("sweep data", 32'(win[obs0[6:5]]), 32'(base + 3 - int'(obs0[6:5])));
                end
            end
            check("loads per strobe", 32'(nld), 32'd1);
            check("taps per strobe", 32'(ntap), (k == 3) ? 32'd4 : 32'd0);
        end
        check("window_full after 4 loads", 32'(obs0[1]), 32'd1);

        // Full window, single strobe: latency profile
        for (int j = 0; j < 8; j++) begin
            step(j == 0);
            v_ld[j] = obs0[8]; v_tv[j] = obs0[7]; v_tf[j] = obs0[4];
            v_tl[j] = obs0[3]; v_bz[j] = obs0[2];
        end
        check("single load timing", 32'(v_ld[7:0]), 32'h02);
        check("single tap_valid timing", 32'(v_tv[7:0]), 32'h3c);
        check("single tap_first timing", 32'(v_tf[7:0]), 32'h04);
        check("single tap_last timing", 32'(v_tl[7:0]), 32'h20);
        check("single busy timing", 32'(v_bz[7:0]), 32'h3e);

        // Full window, strobes at N and N+2: second one pended
        for (int j = 0; j < 12; j++) begin
            step(j == 0 || j == 2);
            v_ld[j] = obs0[8]; v_tv[j] = obs0[7]; v_ov[j] = obs0[0];
        end
        check("pended load timing", 32'(v_ld), 32'h042);
        check("pended tap timing", 32'(v_tv), 32'h7bc);
        check("pended no overrun", 32'(v_ov), 32'h000);

        // Full window, strobes at N, N+2, N+3: third dropped
        for (int j = 0; j < 10; j++) begin
            step(j == 0 || j == 2 || j == 3);
            v_ov[j] = obs0[0];
        end
        check("overrun timing", 32'(v_ov[9:0]), 32'h3f0);
        repeat (6) step(1'b0);
        check("overrun sticky", 32'(obs0[0]), 32'd1);

        // Flush at address 1 of a sweep
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0, 1'b1);
        check("flush at tap 1", 32'(obs0[7:5]), 32'b101);
        step(1'b0);
        check("state after flush", 32'(obs0), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            ntap = 0;
            for (int j = 0; j < 6; j++) begin
                step(1'b0);
                if (obs0[7]) ntap++;
            end
            check("taps after flush", 32'(ntap), (k == 3) ? 32'd4 : 32'd0);
        end

        // READ_BEFORE_FULL=1: sweep after the first load, reset mid-sweep
        step(1'b0, 1'b0, 1'b1);
        step(1'b1);
        step(1'b0);
        check("rbf load", 32'(obs1[8]), 32'd1);
        step(1'b0);
        check("rbf first tap", 32'({obs1[7], obs1[4]}), 32'b11);
        step(1'b0, 1'b0, 1'b1);
        check("rbf tap 1 before reset", 32'(obs1[6:5]), 32'd1);
        step(1'b0);
        check("rbf reset values", 32'(obs1), 32'd0);
        check("dut0 reset values", 32'(obs0), 32'd0);

        // Randomised traffic against the model, varying strobe density
        for (int i = 0; i < 2000; i++) begin
            case ((i / 250) % 4)
                0: thr = 10;
                1: thr = 30;
                2: thr = 60;
                default: thr = 95;
            endcase
            step($urandom_range(0, 99) < thr, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 499) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
